event_fifo: RTL and testbench
=============================

Name: event_fifo

Overview:
- Buffers 9-bit event words arriving on a one-cycle write strobe.
- Exposes the buffered events to software through an AXI4-Lite slave register window: status, fill level, drop counter, flush control, and a pop-on-read data register.
- Sits between the event receiver datapath and the host register bus; one clock domain.

Parameters:
- DEPTH, 512, number of FIFO entries (power of two, ≥4).
- ADDR_W, 32, AXI address width. Only addr[7:0] is decoded.

Ports:
- aclk  input  1  system/AXI clock; all logic is rising-edge.
- aresetn  input  1  asynchronous, active-low reset.
- wr_en  input  1  push strobe; one event per cycle while high.
- data_in  input  9  event word. [7:0] is the event code and is stored. [8] is a control flag and is not stored.
- axi  interface  axi4_lite_if, slave modport  register access: 32-bit data, 4-bit wstrb, 2-bit resp.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, drop counter=0.
- Reset values on the AXI side: arready=0, rvalid=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bresp=0.
- Reset mid-operation discards all contents and aborts any in-flight AXI transaction.
- Push: on a rising edge with wr_en=1 and FIFO not full, store data_in[7:0] at the write pointer and increment it.
  - Entry is visible to status/count on the next cycle.
  - wr_en=1 while full: word dropped, drop counter +1 (saturates at 0xFFFF_FFFF), contents unchanged.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Register map (32-bit, word aligned):
  - 0x00 STATUS (RO): bit0=empty, bit1=full, others 0.
  - 0x04 COUNT (RO): number of stored entries.
  - 0x08 DROPS (RO): overflow drop counter.
  - 0x0C CONTROL (WO, reads 0): writing bit0=1 flushes the FIFO (pointers/count to 0) and clears DROPS. Self-clearing.
  - 0x10: reserved, reads 0.
  - 0x14 DATA (RO, destructive): returns {24'b0, oldest entry} and pops it. If empty, returns 0 and does not pop.
  - Unmapped offsets read 0; writes to them are ignored. All responses are OKAY (2'b00).
- Read channel:
  - arready is asserted one cycle after arvalid is seen while idle; the handshake completes on the edge where arvalid and arready are both high.
  - arready is high for exactly one cycle per transaction.
  - Address is captured and the register is sampled at the handshake edge.
  - rvalid rises on the following cycle with rdata valid, and is held until rvalid&&rready.
  - No new AR is accepted while rvalid is pending.
  - Pop occurs at the AR handshake, so back-to-back DATA reads return consecutive entries.
  - STATUS read in the cycle after a DATA pop reflects the pop.
- Write channel:
  - awready and wready are asserted together for one cycle once both awvalid and wvalid are high; wstrb is ignored.
  - bvalid follows on the next cycle and is held until bready.
- Simultaneous push and pop on the same edge:
  - count unchanged.
  - If the FIFO was full, the push is accepted (not dropped).
  - If the FIFO was empty, the read returns 0 and the push is stored.
- Simultaneous push and flush: flush wins; the pushed word is discarded.

Test Plan:
- After reset, read 0x00 -> 0x1 (empty); read 0x04 -> 0; read 0x14 -> 0.
- Push 0x001, 0x002, 0x003, 0x004 on consecutive cycles, then read 0x00 -> 0x0 and 0x04 -> 4. Read 0x14 four times -> 0x1, 0x2, 0x3, 0x4. Read 0x00 -> 0x1.
- Hold wr_en=1 with data_in=0x10F for 10000 cycles, then read 0x00 -> 0x2 (full), 0x04 -> DEPTH, 0x08 -> 10000-DEPTH. Read 0x14 -> 0xF (bit 8 stripped).
- When full, assert wr_en in the same cycle as a DATA pop -> count stays DEPTH and DROPS does not increment.
- Write 0x1 to 0x0C -> bresp=OKAY; then 0x00 -> 0x1, 0x04 -> 0, 0x08 -> 0.
- Pulse aresetn low during a pending read with data stored -> rvalid drops; after release, 0x00 reads 0x1.

Source files
------------

// File: rtl/event_fifo_if.sv
// AXI4-Lite register-bus interface: 32-bit data, byte strobes, 2-bit responses.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/event_fifo.sv
// Event word FIFO (8-bit payload) with an AXI4-Lite register window for
// status, fill level, overflow drop count, flush and pop-on-read data.
module event_fifo #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 32
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       wr_en,
    input  logic [8:0] data_in,
    axi4_lite_if.slave axi
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [7:0] A_STATUS  = 8'h00;
    localparam logic [7:0] A_COUNT   = 8'h04;
    localparam logic [7:0] A_DROPS   = 8'h08;
    localparam logic [7:0] A_CONTROL = 8'h0C;
    localparam logic [7:0] A_DATA    = 8'h14;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ACK  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_drops;

    rd_state_e        r_rd_state;
    rd_state_e        w_rd_next;
    logic             r_arready;
    logic             r_rvalid;
    logic             w_arready_nxt;
    logic             w_rvalid_nxt;
    logic [31:0]      r_rdata;

    wr_state_e        r_wr_state;
    wr_state_e        w_wr_next;
    logic             r_awready;
    logic             r_bvalid;
    logic             w_awready_nxt;
    logic             w_bvalid_nxt;

    logic             w_empty;
    logic             w_full;
    logic             w_ar_hs;
    logic             w_aw_hs;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_flush;
    logic [7:0]       w_raddr;
    logic [7:0]       w_waddr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_raddr = axi.araddr[7:0];
    assign w_waddr = axi.awaddr[7:0];

    assign w_empty = (r_count == CNT_W'(0));
    assign w_full  = (r_count == CNT_W'(DEPTH));

    assign w_ar_hs = (r_rd_state == RD_ACK) && axi.arvalid;
    assign w_aw_hs = (r_wr_state == WR_ACK) && axi.awvalid && axi.wvalid;

    assign w_flush = w_aw_hs && (w_waddr == A_CONTROL) && axi.wdata[0];
    assign w_pop   = w_ar_hs && (w_raddr == A_DATA) && !w_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign w_push  = wr_en && (!w_full || w_pop) && !w_flush;
    assign w_drop  = wr_en && w_full && !w_pop && !w_flush;

    // Register read mux, sampled at the AR handshake.
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_raddr)
            A_STATUS: w_rd_mux = {30'h0, w_full, w_empty};
            A_COUNT:  w_rd_mux = 32'(r_count);
            A_DROPS:  w_rd_mux = r_drops;
            A_DATA:   w_rd_mux = w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr]};
            default:  w_rd_mux = 32'h0;
        endcase
    end

    // Storage array has no reset; validity is tracked by pointers and count.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drops  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drops  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop && (r_drops != 32'hFFFF_FFFF)) begin
                r_drops <= r_drops + 32'd1;
            end
        end
    end

    // Read channel: state and registered outputs.
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (axi.arvalid) w_rd_next = RD_ACK;
            RD_ACK:  w_rd_next = axi.arvalid ? RD_RESP : RD_IDLE;
            RD_RESP: if (axi.rready) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
        case (w_rd_next)
            RD_ACK:  w_arready_nxt = 1'b1;
            RD_RESP: w_rvalid_nxt  = 1'b1;
            default: begin
                w_arready_nxt = 1'b0;
                w_rvalid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rdata <= '0;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_mux;
        end
    end

    // Write channel: state and registered outputs.
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= w_awready_nxt;
            r_bvalid   <= w_bvalid_nxt;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (axi.awvalid && axi.wvalid) w_wr_next = WR_ACK;
            WR_ACK:  w_wr_next = w_aw_hs ? WR_RESP : WR_IDLE;
            WR_RESP: if (axi.bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        w_awready_nxt = 1'b0;
        w_bvalid_nxt  = 1'b0;
        case (w_wr_next)
            WR_ACK:  w_awready_nxt = 1'b1;
            WR_RESP: w_bvalid_nxt  = 1'b1;
            default: begin
                w_awready_nxt = 1'b0;
                w_bvalid_nxt  = 1'b0;
            end
        endcase
    end

    assign axi.arready = r_arready;
    assign axi.rvalid  = r_rvalid;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = 2'b00;
    assign axi.awready = r_awready;
    assign axi.wready  = r_awready;
    assign axi.bvalid  = r_bvalid;
    assign axi.bresp   = 2'b00;

    // Bits outside the decoded window or not carried by the FIFO.
    assign w_unused = ^{data_in[8], axi.wstrb, axi.wdata[31:1],
                        axi.araddr[ADDR_W-1:8], axi.awaddr[ADDR_W-1:8]};

endmodule

// File: tb/tb_event_fifo.sv
// Directed bench for event_fifo: register reads/writes, overflow, flush,
// simultaneous push/pop and mid-transaction reset.
module tb_event_fifo;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned FLOOD = 10000;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       wr_en;
    logic [8:0] data_in;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;
    logic [1:0]  rsp;

    axi4_lite_if #(.ADDR_W(32)) axi ();

    event_fifo #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (wr_en),
        .data_in (data_in),
        .axi     (axi)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full read; optionally pulses wr_en on the AR handshake edge.
    task automatic axi_read(input logic [7:0] a, input logic push, input logic [8:0] pd,
                            output logic [31:0] d, output logic [1:0] resp);
        bit ok;
        d    = 32'hDEAD_BEEF;
        resp = 2'b11;
        @(negedge aclk);
        axi.araddr  = 32'(a);
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (axi.arready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("arready_timeout", {31'h0, ok}, 32'd1);
        if (push) begin
            wr_en   = 1'b1;
            data_in = pd;
        end
        @(negedge aclk);
        axi.arvalid = 1'b0;
        wr_en       = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (axi.rvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (!ok) check("rvalid_timeout", {31'h0, ok}, 32'd1);
        d    = axi.rdata;
        resp = axi.rresp;
        @(negedge aclk);
        axi.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] wd, output logic [1:0] resp);
        bit ok;
        resp = 2'b11;
        @(negedge aclk);
        axi.awaddr  = 32'(a);
        axi.wdata   = wd;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (axi.awready === 1'b1 && axi.wready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("awready_timeout", {31'h0, ok}, 32'd1);
        @(negedge aclk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (axi.bvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (!ok) check("bvalid_timeout", {31'h0, ok}, 32'd1);
        resp = axi.bresp;
        @(negedge aclk);
        axi.bready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, 1'b0, 9'h0, d, r);
        check(tag, d, exp);
    endtask

    initial begin
        bit ok;
        aresetn     = 1'b0;
        wr_en       = 1'b0;
        data_in     = 9'h0;
        axi.awaddr  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_arready", {31'h0, axi.arready}, 32'd0);
        check("rst_rvalid",  {31'h0, axi.rvalid},  32'd0);
        check("rst_rdata",   axi.rdata,            32'd0);
        check("rst_awready", {31'h0, axi.awready}, 32'd0);
        check("rst_bvalid",  {31'h0, axi.bvalid},  32'd0);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);

        axi_read(8'h00, 1'b0, 9'h0, rd, rsp);
        check("rst_status", rd, 32'h1);
        check("rst_rresp", {30'h0, rsp}, 32'h0);
        rd_check("rst_count", 8'h04, 32'd0);
        rd_check("rst_data_empty", 8'h14, 32'd0);

        // Four back-to-back pushes, then drain in order.
        @(negedge aclk);
        wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = 9'(i);
            @(negedge aclk);
        end
        wr_en = 1'b0;
        rd_check("four_status", 8'h00, 32'h0);
        rd_check("four_count",  8'h04, 32'd4);
        rd_check("pop1", 8'h14, 32'h1);
        rd_check("pop2", 8'h14, 32'h2);
        rd_check("pop3", 8'h14, 32'h3);
        rd_check("pop4", 8'h14, 32'h4);
        rd_check("drained_status", 8'h00, 32'h1);

        rd_check("control_reads0",  8'h0C, 32'h0);
        rd_check("reserved_reads0", 8'h10, 32'h0);
        rd_check("unmapped_reads0", 8'h40, 32'h0);

        // Pop on empty with a same-edge push: read 0, push kept.
        axi_read(8'h14, 1'b1, 9'h1A5, rd, rsp);
        check("empty_pop_push_rdata", rd, 32'h0);
        rd_check("empty_pop_push_count", 8'h04, 32'd1);
        rd_check("empty_pop_push_data", 8'h14, 32'hA5);
        rd_check("empty_pop_push_after", 8'h04, 32'd0);

        // Overflow flood.
        @(negedge aclk);
        wr_en   = 1'b1;
        data_in = 9'h10F;
        repeat (FLOOD) @(negedge aclk);
        wr_en = 1'b0;
        rd_check("flood_status", 8'h00, 32'h2);
        rd_check("flood_count",  8'h04, 32'(DEPTH));
        rd_check("flood_drops",  8'h08, 32'(FLOOD - DEPTH));
        rd_check("flood_data",   8'h14, 32'h0F);
        rd_check("flood_count_after_pop", 8'h04, 32'(DEPTH - 1));

        // Refill, then pop with a same-edge push while full.
        @(negedge aclk);
        wr_en   = 1'b1;
        data_in = 9'h055;
        @(negedge aclk);
        wr_en = 1'b0;
        rd_check("refill_count", 8'h04, 32'(DEPTH));
        axi_read(8'h14, 1'b1, 9'h0AA, rd, rsp);
        check("full_pop_push_rdata", rd, 32'h0F);
        rd_check("full_pop_push_count",  8'h04, 32'(DEPTH));
        rd_check("full_pop_push_drops",  8'h08, 32'(FLOOD - DEPTH));
        rd_check("full_pop_push_status", 8'h00, 32'h2);

        axi_write(8'h20, 32'h1, rsp);
        check("unmapped_bresp", {30'h0, rsp}, 32'h0);
        rd_check("unmapped_write_count", 8'h04, 32'(DEPTH));

        axi_write(8'h0C, 32'h1, rsp);
        check("flush_bresp", {30'h0, rsp}, 32'h0);
        rd_check("flush_status", 8'h00, 32'h1);
        rd_check("flush_count",  8'h04, 32'd0);
        rd_check("flush_drops",  8'h08, 32'd0);

        // Control write with bit0 clear must not flush.
        @(negedge aclk);
        wr_en   = 1'b1;
        data_in = 9'h033;
        @(negedge aclk);
        data_in = 9'h044;
        @(negedge aclk);
        wr_en = 1'b0;
        axi_write(8'h0C, 32'h0, rsp);
        rd_check("noflush_count", 8'h04, 32'd2);

        // Reset while a DATA read response is pending.
        @(negedge aclk);
        axi.araddr  = 32'h14;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (axi.arready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("pend_ar_timeout", {31'h0, ok}, 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        @(negedge aclk);
        check("pend_rvalid", {31'h0, axi.rvalid}, 32'd1);
        check("pend_rdata",  axi.rdata, 32'h33);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'h0, axi.rvalid}, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        rd_check("rst_mid_status", 8'h00, 32'h1);
        rd_check("rst_mid_count",  8'h04, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
